// File: rtl/vec_load_unit.sv
// Frame assembler: header, length and element bytes in, one vector write out for the register bank.
// Optional checksum byte after the data when VEC_LOAD_CHECKSUM_EN is defined.
module vec_load_unit #(
  parameter int BITS = 8,
  parameter int N    = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [BITS-1:0]          s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic [N-1:0][BITS-1:0]   vec_out,
  output logic [BITS-1:0]          len_out,
  output logic [3:0]               sel_out,
  output logic                     write,
  output logic                     busy,
  output logic                     err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN    = 3'd1,
    S_DATA   = 3'd2,
    S_CHK    = 3'd3,
    S_COMMIT = 3'd4
  } state_t;

  localparam logic [BITS-1:0] N_L = BITS'(N);

  state_t                   r_state;
  state_t                   w_next;
  state_t                   w_tail;
  logic [BITS-1:0]          r_cnt;
  logic [BITS-1:0]          r_raw;
  logic [BITS-1:0]          r_len;
  logic [3:0]               r_sel;
  logic [N-1:0][BITS-1:0]   r_vec;
  logic                     w_xfer;
  logic                     w_hdr_xfer;
  logic                     w_dat_xfer;
  logic                     w_commit;
  logic                     w_over;

  assign w_xfer     = s_valid && s_ready;
  assign w_hdr_xfer = w_xfer && (r_state == S_IDLE);
  assign w_dat_xfer = w_xfer && (r_state == S_DATA);
  assign w_commit   = (r_state == S_COMMIT);
  assign w_over     = (r_raw > N_L);

`ifdef VEC_LOAD_CHECKSUM_EN
  assign w_tail = S_CHK;
`else
  assign w_tail = S_COMMIT;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    s_ready = 1'b1;
    case (r_state)
      S_IDLE: if (w_xfer) w_next = S_LEN;
      S_LEN:  if (w_xfer) w_next = (s_data == '0) ? w_tail : S_DATA;
      S_DATA: if (w_xfer && (r_cnt == r_raw - 1'b1)) w_next = w_tail;
`ifdef VEC_LOAD_CHECKSUM_EN
      S_CHK:  if (w_xfer) w_next = S_COMMIT;
`endif
      S_COMMIT: begin
        s_ready = 1'b0;
        w_next  = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_raw <= '0;
      r_len <= '0;
      r_sel <= '0;
    end else if (w_xfer) begin
      case (r_state)
        S_IDLE: begin
          r_sel <= s_data[3:0];
          r_cnt <= '0;
        end
        S_LEN: begin
          r_raw <= s_data;
          r_len <= (s_data > N_L) ? N_L : s_data;
        end
        S_DATA:  r_cnt <= r_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  // Each element owns its register; overflow bytes (counter >= N) match no element and vanish.
  for (genvar gi = 0; gi < N; gi++) begin : g_elem
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                  r_vec[gi] <= '0;
      else if (w_hdr_xfer)                         r_vec[gi] <= '0;
      else if (w_dat_xfer && (r_cnt == BITS'(gi))) r_vec[gi] <= s_data;
    end
  end

`ifdef VEC_LOAD_CHECKSUM_EN
  logic [BITS-1:0] r_xor;
  logic            r_chk_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xor     <= '0;
      r_chk_bad <= 1'b0;
    end else if (w_xfer) begin
      case (r_state)
        S_IDLE: begin
          r_xor     <= s_data;
          r_chk_bad <= 1'b0;
        end
        S_LEN, S_DATA: r_xor <= r_xor ^ s_data;
        S_CHK:         r_chk_bad <= (s_data != r_xor);
        default: ;
      endcase
    end
  end

  assign write = w_commit && !r_chk_bad;
  assign err   = w_commit && (w_over || r_chk_bad);
`else
  assign write = w_commit;
  assign err   = w_commit && w_over;
`endif

  assign busy    = (r_state != S_IDLE);
  assign vec_out = r_vec;
  assign len_out = r_len;
  assign sel_out = r_sel;

endmodule

// File: tb/tb_vec_load_unit.sv
// Randomised frame-level bench for vec_load_unit; expected outputs come from a per-frame model
// built from the header, length and data bytes (checksum byte added when VEC_LOAD_CHECKSUM_EN is set).
module tb_vec_load_unit;
  localparam int BITS = 8;
  localparam int N    = 64;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [BITS-1:0]        s_data = '0;
  logic                   s_valid = 1'b0;
  logic                   s_ready;
  logic [N-1:0][BITS-1:0] vec_out;
  logic [BITS-1:0]        len_out;
  logic [3:0]             sel_out;
  logic                   write;
  logic                   busy;
  logic                   err;

  int n_vec = 0;
  int n_bad = 0;
  logic [7:0] q_data[$];

  vec_load_unit #(.BITS(BITS), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .vec_out(vec_out), .len_out(len_out), .sel_out(sel_out),
    .write(write), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Offer one byte starting at a negedge; returns at the negedge after it was accepted.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n;
    if (gap) begin
      s_valid = 1'b0;
      s_data  = 8'($urandom);
      @(posedge clk); @(negedge clk);
    end
    s_valid = 1'b1;
    s_data  = b;
    n = 0;
    while (!s_ready && n < 8) begin
      @(posedge clk); @(negedge clk);
      n++;
    end
    n_vec++;
    if (!s_ready) begin
      n_bad++;
      $display("FAIL ready_timeout: s_ready=%0b after %0d cycles, required 1", s_ready, n);
    end
    @(posedge clk); @(negedge clk);
    s_valid = 1'b0;
    s_data  = 8'($urandom);
  endtask

  task automatic run_frame(input logic [7:0] hdr, input logic [7:0] raw, input int gap_mode,
                           input bit bad_chk, input bit b2b);
    logic [N-1:0][BITS-1:0] exp_vec;
    logic [7:0] bytes[$];
    logic [7:0] chk;
    int  exp_len;
    bit  exp_wr, exp_err, gap;
    exp_len = (int'(raw) > N) ? N : int'(raw);
    exp_vec = '0;
    for (int i = 0; i < exp_len; i++) exp_vec[i] = q_data[i];
    exp_wr  = 1'b1;
    exp_err = (int'(raw) > N);
    chk = hdr ^ raw;
    bytes = {hdr, raw};
    for (int i = 0; i < q_data.size(); i++) begin
      bytes.push_back(q_data[i]);
      chk ^= q_data[i];
    end
`ifdef VEC_LOAD_CHECKSUM_EN
    if (bad_chk) begin
      chk     = chk ^ 8'(1 << $urandom_range(0, 7));
      exp_wr  = 1'b0;
      exp_err = 1'b1;
    end
    bytes.push_back(chk);
`endif
    for (int i = 0; i < bytes.size(); i++) begin
      gap = (gap_mode == 1) ? 1'b1 : (gap_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      send_byte(bytes[i], gap);
      if (i == 0) begin
        n_vec++;
        if (busy !== 1'b1) begin
          n_bad++;
          $display("FAIL busy_in_frame: got %0b required 1", busy);
        end
      end
      if (i != bytes.size() - 1) begin
        n_vec++;
        if (write !== 1'b0) begin
          n_bad++;
          $display("FAIL early_write: byte %0d got write=%0b required 0", i, write);
        end
      end
    end
    n_vec++;
    if (write !== exp_wr) begin
      n_bad++;
      $display("FAIL commit_write: hdr=%h raw=%0d got %0b required %0b", hdr, raw, write, exp_wr);
    end
    n_vec++;
    if (err !== exp_err) begin
      n_bad++;
      $display("FAIL commit_err: hdr=%h raw=%0d got %0b required %0b", hdr, raw, err, exp_err);
    end
    n_vec++;
    if (s_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL commit_ready: got %0b required 0", s_ready);
    end
    n_vec++;
    if (sel_out !== hdr[3:0]) begin
      n_bad++;
      $display("FAIL sel_out: got %h required %h", sel_out, hdr[3:0]);
    end
    n_vec++;
    if (len_out !== 8'(exp_len)) begin
      n_bad++;
      $display("FAIL len_out: got %0d required %0d", len_out, exp_len);
    end
    n_vec++;
    if (vec_out !== exp_vec) begin
      n_bad++;
      $display("FAIL vec_out: raw=%0d got %h required %h", raw, vec_out, exp_vec);
    end
    if (!b2b) begin
      @(posedge clk); @(negedge clk);
      n_vec++;
      if (write !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL after_commit: got write=%0b err=%0b busy=%0b required 0 0 0", write, err, busy);
      end
    end
    $display("frame hdr=%h raw=%0d gaps=%0d bad_chk=%0b write=%0b err=%0b", hdr, raw, gap_mode, bad_chk, exp_wr, exp_err);
  endtask

  task automatic check_reset_state(input string tag);
    n_vec++;
    if (s_ready !== 1'b1 || busy !== 1'b0 || write !== 1'b0 || err !== 1'b0 ||
        len_out !== 8'h00 || sel_out !== 4'h0 || vec_out !== '0) begin
      n_bad++;
      $display("FAIL %s: got ready=%0b busy=%0b write=%0b err=%0b len=%0d sel=%0d vec_nz=%0b required 1 0 0 0 0 0 0",
               tag, s_ready, busy, write, err, len_out, sel_out, (vec_out != '0));
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_state("reset_state");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_state("idle_after_reset");
    $display("test_reset done");
  endtask

  task automatic test_basic();
    q_data = {8'h11, 8'h22, 8'h33, 8'h44};
    run_frame(8'h03, 8'd4, 0, 1'b0, 1'b0);
  endtask

  task automatic test_empty();
    q_data = {};
    run_frame(8'h0F, 8'd0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_overflow();
    q_data = {};
    for (int i = 0; i < 70; i++) q_data.push_back(8'(i));
    run_frame(8'h01, 8'd70, 0, 1'b0, 1'b0);
  endtask

  task automatic test_gaps();
    q_data = {8'h11, 8'h22, 8'h33, 8'h44};
    run_frame(8'h03, 8'd4, 1, 1'b0, 1'b0);
  endtask

  task automatic test_midframe_reset();
    q_data = {8'hA1, 8'hA2, 8'hA3};
    run_frame(8'h07, 8'd3, 0, 1'b0, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'd8, 1'b0);
    send_byte(8'hDE, 1'b0);
    send_byte(8'hAD, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_reset_state("midframe_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_state("post_reset_idle");
    q_data = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    run_frame(8'h05, 8'd8, 0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 4; f++) begin
      q_data = {};
      for (int i = 0; i < f + 2; i++) q_data.push_back(8'($urandom));
      run_frame(8'($urandom), 8'(f + 2), 0, 1'b0, f != 3);
    end
  endtask

`ifdef VEC_LOAD_CHECKSUM_EN
  task automatic test_checksum();
    q_data = {8'h05, 8'h06};
    run_frame(8'h02, 8'd2, 0, 1'b0, 1'b0);
    run_frame(8'h02, 8'd2, 0, 1'b1, 1'b0);
  endtask
`endif

  task automatic test_random();
    int raw;
    for (int f = 0; f < 20; f++) begin
      case ($urandom_range(0, 4))
        0:       raw = $urandom_range(0, 1);
        1:       raw = $urandom_range(N - 1, N + 1);
        2:       raw = 255;
        default: raw = $urandom_range(0, N + 10);
      endcase
      q_data = {};
      for (int i = 0; i < raw; i++) q_data.push_back(8'($urandom));
      run_frame(8'($urandom), 8'(raw), $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
    end
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty();
    test_overflow();
    test_gaps();
    test_midframe_reset();
    test_back_to_back();
`ifdef VEC_LOAD_CHECKSUM_EN
    test_checksum();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
